// File: rtl/cp0_reg.sv
// cp0_reg: MIPS32 CP0 register file with Count/Compare timer, interrupt capture and exception entry/eret.
module cp0_reg #(
  parameter logic [31:0] PRID_VAL   = 32'h004c0102,
  parameter logic [31:0] CONFIG_VAL = 32'h00008000,
  parameter logic [31:0] STATUS_RST = 32'h10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);
  localparam logic [4:0] COUNT = 5'd9, COMPARE = 5'd11, STATUS = 5'd12, CAUSE = 5'd13,
                         EPC = 5'd14, PRID = 5'd15, CONFIG = 5'd16;
  logic       exc_hit;
  logic [4:0] exc_code;
  assign config_o = CONFIG_VAL;
  assign prid_o   = PRID_VAL;
  assign exc_hit  = excepttype_i inside {32'h1, 32'h8, 32'ha, 32'hd, 32'hc};
  assign exc_code = excepttype_i == 32'h1 ? 5'd0  :
                    excepttype_i == 32'h8 ? 5'd8  :
                    excepttype_i == 32'ha ? 5'd10 :
                    excepttype_i == 32'hd ? 5'd13 : 5'd12;
  always_comb begin
    data_o = raddr_i == COUNT   ? count_o   :
             raddr_i == COMPARE ? compare_o :
             raddr_i == STATUS  ? status_o  :
             raddr_i == CAUSE   ? cause_o   :
             raddr_i == EPC     ? epc_o     :
             raddr_i == PRID    ? prid_o    :
             raddr_i == CONFIG  ? config_o  : 32'h0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_o     <= '0;
      compare_o   <= '0;
      status_o    <= STATUS_RST;
      cause_o     <= '0;
      epc_o       <= '0;
      timer_int_o <= 1'b0;
    end else begin
      count_o        <= count_o + 32'd1;
      cause_o[15:10] <= int_i;
      if (compare_o != 32'h0 && count_o == compare_o) timer_int_o <= 1'b1;
      if (we_i) begin
        if (waddr_i == COUNT) count_o <= data_i;
        if (waddr_i == COMPARE) begin
          compare_o   <= data_i;
          timer_int_o <= 1'b0;
        end
        if (waddr_i == STATUS) status_o <= data_i;
        if (waddr_i == EPC) epc_o <= data_i;
        if (waddr_i == CAUSE) begin
          cause_o[9:8]   <= data_i[9:8];
          cause_o[23:22] <= data_i[23:22];
        end
      end
      // exception assignments come last so they override an overlapping mtc0
      if (exc_hit) begin
        if (!status_o[1]) begin
          epc_o       <= is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
          cause_o[31] <= is_in_delayslot_i;
        end
        status_o[1]  <= 1'b1;
        cause_o[6:2] <= exc_code;
      end else if (excepttype_i == 32'he) begin
        status_o[1] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cp0_reg.sv
// tb_cp0_reg: directed-vector bench for cp0_reg with hand-computed expectations.
module tb_cp0_reg;
  logic        clk = 0, rst = 0, we_i = 0, is_in_delayslot_i = 0;
  logic [4:0]  waddr_i = 0, raddr_i = 0;
  logic [5:0]  int_i = 0;
  logic [31:0] data_i = 0, excepttype_i = 0, current_inst_addr_i = 0;
  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
  logic        timer_int_o;
  int          n_cmp = 0, n_err = 0;

  cp0_reg dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .data_i(data_i),
    .raddr_i(raddr_i), .int_i(int_i), .excepttype_i(excepttype_i),
    .current_inst_addr_i(current_inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
    .data_o(data_o), .count_o(count_o), .compare_o(compare_o), .status_o(status_o),
    .cause_o(cause_o), .epc_o(epc_o), .config_o(config_o), .prid_o(prid_o),
    .timer_int_o(timer_int_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we_i = 1; waddr_i = a; data_i = d;
    tick();
    we_i = 0;
  endtask

  task automatic exc(input logic [31:0] t, input logic [31:0] pc, input logic ds);
    excepttype_i = t; current_inst_addr_i = pc; is_in_delayslot_i = ds;
    tick();
    excepttype_i = 0;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_count", count_o, 32'h0);
    chk("rst_status", status_o, 32'h10000000);
    chk("rst_timer", {31'b0, timer_int_o}, 32'h0);
    rst = 1;
    repeat (5) tick();
    chk("idle_count", count_o, 32'd5);
    chk("idle_status", status_o, 32'h10000000);
    chk("prid", prid_o, 32'h004c0102);
    chk("config", config_o, 32'h00008000);
    raddr_i = 15;
    #1 chk("rd_prid", data_o, 32'h004c0102);

    wr(9, 32'h0);
    chk("count_zero", count_o, 32'h0);
    wr(11, 32'd20);
    chk("count_one", count_o, 32'd1);
    repeat (19) tick();
    chk("pre_match_count", count_o, 32'd20);
    chk("pre_match_timer", {31'b0, timer_int_o}, 32'h0);
    tick();
    chk("match_timer", {31'b0, timer_int_o}, 32'h1);
    repeat (3) tick();
    chk("timer_held", {31'b0, timer_int_o}, 32'h1);
    wr(11, 32'd40);
    chk("timer_clr", {31'b0, timer_int_o}, 32'h0);
    raddr_i = 11;
    #1 chk("rd_compare", data_o, 32'd40);

    wr(13, 32'hFFFFFFFF);
    chk("cause_mask", cause_o, 32'h00C00300);
    int_i = 6'b100001;
    tick();
    chk("cause_ip", {26'b0, cause_o[15:10]}, 32'h21);
    int_i = 0;
    tick();

    exc(32'h8, 32'h100, 1);
    chk("exc_epc", epc_o, 32'hFC);
    chk("exc_bd", {31'b0, cause_o[31]}, 32'h1);
    chk("exc_code", {27'b0, cause_o[6:2]}, 32'd8);
    chk("exc_exl", {31'b0, status_o[1]}, 32'h1);
    exc(32'h8, 32'h200, 0);
    chk("nest_epc", epc_o, 32'hFC);
    chk("nest_bd", {31'b0, cause_o[31]}, 32'h1);
    chk("nest_code", {27'b0, cause_o[6:2]}, 32'd8);
    exc(32'ha, 32'h204, 0);
    chk("nest_code_a", {27'b0, cause_o[6:2]}, 32'd10);
    exc(32'he, 32'h300, 0);
    chk("eret_status", status_o, 32'h10000000);
    chk("eret_epc", epc_o, 32'hFC);

    we_i = 1; waddr_i = 12; data_i = 32'h0000FF01;
    exc(32'h1, 32'h300, 0);
    we_i = 0;
    chk("st_exl_force", status_o, 32'h0000FF03);
    chk("st_exc_epc", epc_o, 32'h300);
    chk("st_exc_bd", {31'b0, cause_o[31]}, 32'h0);
    chk("st_exc_code", {27'b0, cause_o[6:2]}, 32'd0);
    we_i = 1; waddr_i = 14; data_i = 32'h1234;
    exc(32'hc, 32'h400, 1);
    we_i = 0;
    chk("epc_wr_exl1", epc_o, 32'h1234);
    chk("code_c", {27'b0, cause_o[6:2]}, 32'd12);
    exc(32'h0, 32'h500, 0);
    chk("no_exc_epc", epc_o, 32'h1234);
    wr(15, 32'h0);
    wr(16, 32'h0);
    chk("prid_ro", prid_o, 32'h004c0102);
    chk("config_ro", config_o, 32'h00008000);
    raddr_i = 5;
    #1 chk("rd_unmapped", data_o, 32'h0);

    wr(9, 32'hFFFFFFFF);
    chk("count_max", count_o, 32'hFFFFFFFF);
    tick();
    chk("count_wrap", count_o, 32'h0);

    wr(9, 32'h0);
    wr(11, 32'd2);
    tick();
    chk("t2_pre", {31'b0, timer_int_o}, 32'h0);
    tick();
    chk("t2_set", {31'b0, timer_int_o}, 32'h1);
    #2 rst = 0;
    #1;
    chk("mid_rst_count", count_o, 32'h0);
    chk("mid_rst_compare", compare_o, 32'h0);
    chk("mid_rst_status", status_o, 32'h10000000);
    chk("mid_rst_cause", cause_o, 32'h0);
    chk("mid_rst_epc", epc_o, 32'h0);
    chk("mid_rst_timer", {31'b0, timer_int_o}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cp0_reg.md
Name: cp0_reg

Overview:
- Coprocessor-0 register file for the 5-stage MIPS32 core; sits directly downstream of the memory-access stage.
- Consumes that stage's CP0 write request, resolved exception code, faulting PC and delay-slot flag.
- Returns Status/Cause/EPC (forwarded back into that stage's exception logic), the mfc0 read port, and the timer interrupt line.
- Implements Count/Compare timer, interrupt-pending capture, EPC/BD/EXL/ExcCode update on exception entry and EXL clear on eret.

Parameters:
- PRID_VAL, 32'h004c0102, read-only PRId contents.
- CONFIG_VAL, 32'h00008000, read-only Config contents (BE=1).
- STATUS_RST, 32'h10000000, Status reset value (CU0=1).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- we_i  in  1  CP0 write enable (mtc0 at writeback).
- waddr_i  in  5  CP0 write register number.
- data_i  in  32  CP0 write data.
- raddr_i  in  5  CP0 read register number (mfc0).
- int_i  in  6  external hardware interrupt lines.
- excepttype_i  in  32  resolved exception code from memory stage (0 = none).
- current_inst_addr_i  in  32  PC of instruction in memory stage.
- is_in_delayslot_i  in  1  that instruction is in a branch delay slot.
- data_o  out  32  read data for raddr_i.
- count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o  out  32 each  register contents.
- timer_int_o  out  1  timer interrupt pending.

Behaviour:
Register map:
- Count=9, Compare=11, Status=12, Cause=13, EPC=14, PRId=15, Config=16.
- Reads of unmapped numbers return 0.
- data_o is combinational from raddr_i. There is no internal bypass; forwarding is done upstream.

Reset (rst low, asynchronous):
- count/compare/cause/epc/data-path registers = 0.
- status_o = STATUS_RST; config_o = CONFIG_VAL; prid_o = PRID_VAL.
- timer_int_o = 0.

Every cycle, out of reset:
- Count increments by 1 and wraps from 32'hFFFFFFFF to 0.
- cause_o[15:10] <= int_i (one-cycle capture latency).
- If compare_o != 0 and count_o == compare_o, timer_int_o <= 1. It stays set until Compare is written.

Writes (we_i=1), applied at the next edge:
- Count: value written replaces that cycle's increment.
- Compare: loads data_i and clears timer_int_o the same edge.
- Status: all 32 bits writable.
- EPC: all 32 bits writable.
- Cause: only bits [9:8] (IP1:0), [22] (WP) and [23] (IV) change; all other Cause bits are preserved.
- PRId, Config and unmapped numbers: writes are ignored.

Exception update (same edge, evaluated after the write, so it wins on any overlapping field):
- Codes 32'h1/8/a/d/c map to ExcCode 0/8/10/13/12 respectively. For each:
  - If status_o[1] (EXL) == 0: epc_o <= is_in_delayslot_i ? current_inst_addr_i-4 : current_inst_addr_i; cause_o[31] (BD) <= is_in_delayslot_i.
  - If EXL == 1: EPC and BD are unchanged.
  - In both cases: status_o[1] <= 1; cause_o[6:2] <= ExcCode.
- 32'he (eret): status_o[1] <= 0 only.
- Any other value, including 0: no exception update.
- Write and exception to the same field in one cycle: the exception result is stored. Non-overlapping fields of the write still apply.

Reset mid-operation:
- Asserting rst clears all state immediately, including a pending timer_int_o, regardless of clk.

Test Plan:
1. Release reset, idle 5 cycles -> count_o=5, status_o=32'h10000000, prid_o=32'h004c0102, config_o=32'h00008000, data_o with raddr_i=15 returns 32'h004c0102.
2. Write Compare=20 with Count at 0 -> timer_int_o rises on the edge where count_o==20 and stays 1. Write Compare=40 -> timer_int_o=0 the next cycle.
3. excepttype_i=8, current_inst_addr_i=32'h100, is_in_delayslot_i=1, EXL=0 -> epc_o=32'hFC, cause_o[31]=1, cause_o[6:2]=8, status_o[1]=1. Repeat with addr 32'h200 -> epc_o stays 32'hFC, ExcCode=8.
4. excepttype_i=32'he after scenario 3 -> status_o[1]=0, epc_o unchanged.
5. Write Cause=32'hFFFFFFFF -> cause_o = 32'h00C00300 (only bits 23,22,9,8 set, int_i=0). Then int_i=6'b100001 -> cause_o[15:10]=6'b100001 one cycle later.
6. Same-cycle mtc0 Status=32'h0000FF01 and excepttype_i=32'h1 -> status_o=32'h0000FF03 (EXL forced). Write Count=32'hFFFFFFFF -> next cycle count_o=0. Assert rst mid-count -> all outputs at reset values immediately.
